// File: rtl/wb_reg_slave_if.sv
// rtl/wb_reg_slave_if.sv - host-side Wishbone signals and register-file port of wb_reg_slave
interface wb_reg_slave_if #(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 16,
    parameter int NUM_REGS = 4
);
    localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam int SEL_W = DATA_W / 8;

    logic              cyc;
    logic              stb;
    logic              we;
    logic [ADDR_W-1:0] adr;
    logic [DATA_W-1:0] wdata;
    logic [SEL_W-1:0]  sel;
    logic [DATA_W-1:0] reg_rdata;
    logic              ack;
    logic              err;
    logic [DATA_W-1:0] rdata;
    logic [IDX_W-1:0]  reg_idx;
    logic [DATA_W-1:0] reg_wdata;
    logic [SEL_W-1:0]  reg_sel;
    logic              reg_we;
    logic              reg_re;

    modport master (
        output cyc, stb, we, adr, wdata, sel, reg_rdata,
        input  ack, err, rdata, reg_idx, reg_wdata, reg_sel, reg_we, reg_re
    );

    modport slave (
        input  cyc, stb, we, adr, wdata, sel, reg_rdata,
        output ack, err, rdata, reg_idx, reg_wdata, reg_sel, reg_we, reg_re
    );
endinterface

// File: rtl/wb_reg_slave.sv
// rtl/wb_reg_slave.sv - Wishbone classic slave onto an indexed register file
// Optional macro WB_ERR_EN: bad addresses terminate with err instead of ack.
module wb_reg_slave #(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 16,
    parameter int BASE_ADR = 0,
    parameter int NUM_REGS = 4,
    parameter int STRIDE   = 2,
    parameter int RD_LAT   = 0
) (
    input logic           i_wb_clk,
    input logic           i_wb_rst,
    wb_reg_slave_if.slave bus
);
    localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam int SEL_W = DATA_W / 8;
    localparam int SH    = $clog2(STRIDE);
    localparam logic [ADDR_W:0]   BASE_X   = (ADDR_W+1)'(BASE_ADR);
    localparam logic [ADDR_W:0]   NUM_X    = (ADDR_W+1)'(NUM_REGS);
    localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'(STRIDE - 1);

    typedef enum logic [1:0] {IDLE, RD_WAIT, RESP} state_t;

    state_t            state;
    logic [2:0]        cnt;
    logic              ack_q;
    logic [DATA_W-1:0] rdata_q;
    logic [IDX_W-1:0]  reg_idx_q;
    logic [DATA_W-1:0] reg_wdata_q;
    logic [SEL_W-1:0]  reg_sel_q;
    logic              reg_we_q;
    logic              reg_re_q;
`ifdef WB_ERR_EN
    logic              err_q;
`endif

    // The extra top bit of diff is the borrow, i.e. adr below BASE_ADR.
    logic [ADDR_W:0]   diff;
    logic [ADDR_W-1:0] off;
    logic [ADDR_W-1:0] slot;
    logic              adr_ok;

    always_comb begin
        diff   = {1'b0, bus.adr} - BASE_X;
        off    = diff[ADDR_W-1:0];
        slot   = off >> SH;
        adr_ok = !diff[ADDR_W] && ((off & OFF_MASK) == '0) && ({1'b0, slot} < NUM_X);
    end

    always_ff @(posedge i_wb_clk) begin
        if (i_wb_rst) begin
            state       <= IDLE;
            cnt         <= '0;
            ack_q       <= 1'b0;
            rdata_q     <= '0;
            reg_idx_q   <= '0;
            reg_wdata_q <= '0;
            reg_sel_q   <= '0;
            reg_we_q    <= 1'b0;
            reg_re_q    <= 1'b0;
`ifdef WB_ERR_EN
            err_q       <= 1'b0;
`endif
        end else begin
            ack_q    <= 1'b0;
            reg_we_q <= 1'b0;
            reg_re_q <= 1'b0;
`ifdef WB_ERR_EN
            err_q    <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (bus.cyc && bus.stb) begin
                        if (adr_ok) begin
                            reg_idx_q <= IDX_W'(slot);
                            reg_sel_q <= bus.sel;
                            if (bus.we) begin
                                reg_wdata_q <= bus.wdata;
                                reg_we_q    <= 1'b1;
                                ack_q       <= 1'b1;
                                state       <= RESP;
                            end else begin
                                reg_re_q <= 1'b1;
                                cnt      <= 3'(RD_LAT);
                                state    <= RD_WAIT;
                            end
                        end else begin
`ifdef WB_ERR_EN
                            err_q <= 1'b1;
`else
                            ack_q <= 1'b1;
                            if (!bus.we) begin
                                rdata_q <= '0;
                            end
`endif
                            state <= RESP;
                        end
                    end
                end
                RD_WAIT: begin
                    // Host dropping cyc abandons the read without a termination.
                    if (!bus.cyc) begin
                        state <= IDLE;
                    end else if (cnt == 3'd0) begin
                        rdata_q <= bus.reg_rdata;
                        ack_q   <= 1'b1;
                        state   <= RESP;
                    end else begin
                        cnt <= cnt - 3'd1;
                    end
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.ack       = ack_q;
    assign bus.rdata     = rdata_q;
    assign bus.reg_idx   = reg_idx_q;
    assign bus.reg_wdata = reg_wdata_q;
    assign bus.reg_sel   = reg_sel_q;
    assign bus.reg_we    = reg_we_q;
    assign bus.reg_re    = reg_re_q;
`ifdef WB_ERR_EN
    assign bus.err       = err_q;
`else
    assign bus.err       = 1'b0;
`endif
endmodule

// File: tb/tb_wb_reg_slave.sv
// tb/tb_wb_reg_slave.sv - scoreboard bench for wb_reg_slave on two parameter sets
module tb_wb_reg_slave;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cycn = 0;
    always @(posedge clk) cycn <= cycn + 1;

    int checks   = 0;
    int failures = 0;

    logic [1:0]  rst;
    logic [1:0]  h_cyc, h_stb, h_we;
    logic [15:0] h_adr [2];
    logic [15:0] h_wd  [2];
    logic [1:0]  h_sel [2];
    logic [15:0] h_rd  [2];

    wire  [1:0]  o_ack, o_err, o_we, o_re;
    wire  [15:0] o_rd  [2];
    wire  [15:0] o_wd  [2];
    wire  [2:0]  o_idx [2];
    wire  [1:0]  o_sel [2];

    wb_reg_slave_if #(.DATA_W(16), .ADDR_W(16), .NUM_REGS(4)) b0 ();
    wb_reg_slave_if #(.DATA_W(16), .ADDR_W(16), .NUM_REGS(8)) b1 ();

    wb_reg_slave #(.DATA_W(16), .ADDR_W(16), .BASE_ADR(0), .NUM_REGS(4), .STRIDE(2), .RD_LAT(2))
        u0 (.i_wb_clk(clk), .i_wb_rst(rst[0]), .bus(b0.slave));
    wb_reg_slave #(.DATA_W(16), .ADDR_W(16), .BASE_ADR(16'h0100), .NUM_REGS(8), .STRIDE(4), .RD_LAT(3))
        u1 (.i_wb_clk(clk), .i_wb_rst(rst[1]), .bus(b1.slave));

    assign b0.cyc = h_cyc[0];  assign b1.cyc = h_cyc[1];
    assign b0.stb = h_stb[0];  assign b1.stb = h_stb[1];
    assign b0.we  = h_we[0];   assign b1.we  = h_we[1];
    assign b0.adr = h_adr[0];  assign b1.adr = h_adr[1];
    assign b0.wdata = h_wd[0]; assign b1.wdata = h_wd[1];
    assign b0.sel = h_sel[0];  assign b1.sel = h_sel[1];
    assign b0.reg_rdata = h_rd[0]; assign b1.reg_rdata = h_rd[1];

    assign o_ack[0] = b0.ack;  assign o_ack[1] = b1.ack;
    assign o_err[0] = b0.err;  assign o_err[1] = b1.err;
    assign o_we[0]  = b0.reg_we; assign o_we[1] = b1.reg_we;
    assign o_re[0]  = b0.reg_re; assign o_re[1] = b1.reg_re;
    assign o_rd[0]  = b0.rdata;  assign o_rd[1] = b1.rdata;
    assign o_wd[0]  = b0.reg_wdata; assign o_wd[1] = b1.reg_wdata;
    assign o_idx[0] = {1'b0, b0.reg_idx}; assign o_idx[1] = b1.reg_idx;
    assign o_sel[0] = b0.reg_sel; assign o_sel[1] = b1.reg_sel;

    typedef struct { bit err; logic [15:0] data; int at; } resp_t;
    typedef struct { bit we; logic [2:0] idx; logic [15:0] wd; logic [1:0] sel; int at; } strb_t;

    resp_t rq0[$], rq1[$];
    strb_t sq0[$], sq1[$];
    logic [15:0] last_rd [2];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic mon(input int d);
        resp_t r;
        strb_t s;
        bit    have;
        chk($sformatf("dut%0d_we_re_exclusive", d), o_we[d] & o_re[d], 0);
        if (o_ack[d] || o_err[d]) begin
            have = 0;
            if (d == 0 && rq0.size() > 0) begin r = rq0.pop_front(); have = 1; end
            if (d == 1 && rq1.size() > 0) begin r = rq1.pop_front(); have = 1; end
            if (!have) chk($sformatf("dut%0d_unexpected_resp", d), 1, 0);
            else begin
                chk($sformatf("dut%0d_err", d), o_err[d], r.err);
                chk($sformatf("dut%0d_ack", d), o_ack[d], !r.err);
                chk($sformatf("dut%0d_rdata", d), o_rd[d], r.data);
                chk($sformatf("dut%0d_resp_cycle", d), cycn, r.at);
            end
        end
        if (o_we[d] || o_re[d]) begin
            have = 0;
            if (d == 0 && sq0.size() > 0) begin s = sq0.pop_front(); have = 1; end
            if (d == 1 && sq1.size() > 0) begin s = sq1.pop_front(); have = 1; end
            if (!have) chk($sformatf("dut%0d_unexpected_strobe", d), 1, 0);
            else begin
                chk($sformatf("dut%0d_reg_we", d), o_we[d], s.we);
                chk($sformatf("dut%0d_reg_re", d), o_re[d], !s.we);
                chk($sformatf("dut%0d_reg_idx", d), o_idx[d], s.idx);
                chk($sformatf("dut%0d_reg_sel", d), o_sel[d], s.sel);
                if (s.we) chk($sformatf("dut%0d_reg_wdata", d), o_wd[d], s.wd);
                chk($sformatf("dut%0d_strobe_cycle", d), cycn, s.at);
            end
        end
    endtask

    always @(negedge clk) begin
        mon(0);
        mon(1);
    end

    task automatic push_strb(input int d, input bit w, input logic [2:0] idx,
                             input logic [15:0] wd, input logic [1:0] sel, input int at);
        strb_t s;
        s.we = w; s.idx = idx; s.wd = wd; s.sel = sel; s.at = at;
        if (d == 0) sq0.push_back(s); else sq1.push_back(s);
    endtask

    task automatic drive(input int d, input bit w, input logic [15:0] a,
                         input logic [15:0] wd, input logic [1:0] sel);
        h_cyc[d] = 1'b1; h_stb[d] = 1'b1; h_we[d] = w;
        h_adr[d] = a; h_wd[d] = wd; h_sel[d] = sel; h_rd[d] = 16'hDEAD;
    endtask

    task automatic xfer(input int d, input bit w, input logic [15:0] a, input logic [15:0] wd,
                        input logic [1:0] sel, input logic [15:0] rv, input bit ok,
                        input logic [2:0] idx);
        int    t, lat;
        bit    done;
        resp_t r;
        lat = (d == 0) ? 2 : 3;
        @(posedge clk); #1;
        drive(d, w, a, wd, sel);
        t = cycn;
        r.err = 0;
        if (ok) begin
            push_strb(d, w, idx, wd, sel, t + 1);
            if (w) r.at = t + 1;
            else begin r.at = t + 2 + lat; last_rd[d] = rv; end
        end else begin
            r.at = t + 1;
`ifdef WB_ERR_EN
            r.err = 1;
`else
            if (!w) last_rd[d] = 16'h0000;
`endif
        end
        r.data = last_rd[d];
        if (d == 0) rq0.push_back(r); else rq1.push_back(r);
        done = 0;
        for (int i = 0; i < 20 && !done; i++) begin
            @(posedge clk); #1;
            h_rd[d] = (cycn == t + 1 + lat) ? rv : 16'hDEAD;
            if (o_ack[d] || o_err[d]) done = 1;
        end
        if (!done) chk($sformatf("dut%0d_timeout_adr_%0h", d, a), 0, 1);
        // Keep stb up through the termination cycle; it must not start a second transfer.
        @(posedge clk); #1;
        h_cyc[d] = 1'b0; h_stb[d] = 1'b0;
    endtask

    task automatic chk_zero(input int d, input string tag);
        chk({tag, "_ctl"}, {o_ack[d], o_err[d], o_we[d], o_re[d], o_idx[d], o_sel[d]}, 0);
        chk({tag, "_rdata"}, o_rd[d], 0);
        chk({tag, "_reg_wdata"}, o_wd[d], 0);
    endtask

    initial begin
        int t;
        rst = 2'b11; h_cyc = '0; h_stb = '0; h_we = '0;
        for (int i = 0; i < 2; i++) begin
            h_adr[i] = '0; h_wd[i] = '0; h_sel[i] = '0; h_rd[i] = '0; last_rd[i] = '0;
        end
        repeat (3) @(posedge clk);
        #1;
        chk_zero(0, "dut0_reset");
        chk_zero(1, "dut1_reset");
        rst = 2'b00;

        // Base 0, stride 2, 4 registers, read latency 2
        xfer(0, 1, 16'h0004, 16'hABCD, 2'b11, 16'h0000, 1, 3'd2);
        xfer(0, 0, 16'h0006, 16'h0000, 2'b11, 16'h1234, 1, 3'd3);
        xfer(0, 0, 16'h0003, 16'h0000, 2'b01, 16'h7777, 0, 3'd0);
        xfer(0, 0, 16'h0008, 16'h0000, 2'b11, 16'h7777, 0, 3'd0);
        xfer(0, 1, 16'h0000, 16'h5A5A, 2'b01, 16'h0000, 1, 3'd0);
        xfer(0, 0, 16'h0002, 16'h0000, 2'b10, 16'hBEEF, 1, 3'd1);
        xfer(0, 1, 16'h0008, 16'h1111, 2'b11, 16'h0000, 0, 3'd0);
        xfer(0, 1, 16'h0006, 16'h2222, 2'b10, 16'h0000, 1, 3'd3);

        // Base 0x100, stride 4, 8 registers, read latency 3
        xfer(1, 1, 16'h010C, 16'h3C3C, 2'b11, 16'h0000, 1, 3'd3);
        xfer(1, 1, 16'h010E, 16'h4444, 2'b11, 16'h0000, 0, 3'd0);
        xfer(1, 1, 16'h00FC, 16'h5555, 2'b11, 16'h0000, 0, 3'd0);
        xfer(1, 0, 16'h0120, 16'h0000, 2'b11, 16'h6666, 0, 3'd0);
        xfer(1, 0, 16'h011C, 16'h0000, 2'b01, 16'hCAFE, 1, 3'd7);

        // Abort: cyc dropped in T+2 of a read; no termination, next write normal
        @(posedge clk); #1;
        drive(1, 0, 16'h0104, 16'h0000, 2'b11);
        t = cycn;
        push_strb(1, 0, 3'd1, 16'h0000, 2'b11, t + 1);
        repeat (2) @(posedge clk);
        #1;
        h_cyc[1] = 1'b0; h_stb[1] = 1'b0;
        xfer(1, 1, 16'h0100, 16'h0F0F, 2'b11, 16'h0000, 1, 3'd0);

        // Synchronous reset in T+2 of a read
        @(posedge clk); #1;
        drive(1, 0, 16'h0108, 16'h0000, 2'b11);
        t = cycn;
        push_strb(1, 0, 3'd2, 16'h0000, 2'b11, t + 1);
        repeat (2) @(posedge clk);
        #1;
        rst[1] = 1'b1;
        @(posedge clk); #1;
        chk_zero(1, "dut1_mid_reset");
        rst[1] = 1'b0; h_cyc[1] = 1'b0; h_stb[1] = 1'b0;
        last_rd[1] = 16'h0000;
        xfer(1, 1, 16'h0104, 16'h9999, 2'b10, 16'h0000, 1, 3'd1);

        repeat (6) @(posedge clk);
        #1;
        chk("dut0_resp_left", rq0.size(), 0);
        chk("dut0_strobe_left", sq0.size(), 0);
        chk("dut1_resp_left", rq1.size(), 0);
        chk("dut1_strobe_left", sq1.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/wb_reg_slave.md
# wb_reg_slave

Parametrised Wishbone classic slave that bridges a host bus onto a register file of NUM_REGS entries at a configurable base address and stride. It decodes and validates addresses, issues single-cycle register write and read strobes with byte selects, and waits a configurable read latency before returning data. Every transfer gets exactly one single-cycle termination, either ack or err. It sits between the Wishbone host and the PWM/timer register file and replaces the fixed four-register interface.

## Interface
- DATA_W, 16, data bus width; a multiple of 8
- ADDR_W, 16, Wishbone address width
- BASE_ADR, 0, byte address of register index 0
- NUM_REGS, 4, number of registers; at least 1
- STRIDE, 2, address step between registers; a power of two, at least 1
- RD_LAT, 0, register-file read latency in cycles, 0..7
- IDX_W, max(1, clog2(NUM_REGS)), register index width; derived
- i_wb_clk  in  1  system clock
- i_wb_rst  in  1  reset, synchronous, active-high
- i_wb_cyc  in  1  bus cycle valid
- i_wb_stb  in  1  transfer strobe
- i_wb_we  in  1  1 = write, 0 = read
- i_wb_adr  in  ADDR_W  byte address
- i_wb_data  in  DATA_W  write data
- i_wb_sel  in  DATA_W/8  byte selects
- i_reg_data  in  DATA_W  read data from the register file
- o_wb_ack  out  1  transfer done; one-cycle pulse
- o_wb_err  out  1  address error; one-cycle pulse (only with WB_ERR_EN)
- o_wb_data  out  DATA_W  read data returned to the host
- o_reg_idx  out  IDX_W  register index
- o_reg_data  out  DATA_W  write data to the register file
- o_reg_sel  out  DATA_W/8  byte selects to the register file
- o_reg_we  out  1  write strobe; one-cycle pulse
- o_reg_re  out  1  read strobe; one-cycle pulse

## Operation
- **Address valid when all hold:**
  - i_wb_adr >= BASE_ADR;
  - (i_wb_adr − BASE_ADR) mod STRIDE == 0;
  - (i_wb_adr − BASE_ADR)/STRIDE < NUM_REGS.
- **Index:** (i_wb_adr − BASE_ADR)/STRIDE, truncated to IDX_W.
- **States:** IDLE, RD_WAIT, RESP. All outputs are registered.
- **IDLE, request seen (i_wb_cyc & i_wb_stb) in cycle T:**
  - Valid write:
    - o_reg_idx, o_reg_data and o_reg_sel are loaded.
    - o_reg_we = 1 and o_wb_ack = 1 in T+1.
    - Go to RESP.
  - Valid read:
    - o_reg_idx and o_reg_sel are loaded.
    - o_reg_re = 1 in T+1.
    - Go to RD_WAIT with the counter at RD_LAT.
  - Invalid address: no register strobe. Response is defined under Configuration. Go to RESP.
- **RD_WAIT:**
  - The counter decrements each cycle.
  - When it reaches 0, i_reg_data is captured into o_wb_data and o_wb_ack = 1 in the next cycle.
  - Go to RESP.
- **RESP:**
  - Lasts one cycle; ack and err drop to 0.
  - Unconditionally go to IDLE, where the next request is accepted. The host's stb held through the ack cycle is not re-accepted.
- **Abort:** i_wb_cyc = 0 in RD_WAIT → IDLE next cycle, no ack, o_wb_data unchanged.
- **Data hold:**
  - o_wb_data holds the last completed read value.
  - o_reg_idx, o_reg_data and o_reg_sel hold between transfers.
- **Strobe pulses:** o_reg_we and o_reg_re are never high for more than one cycle, and never high together.

## Timing
- **Reset:** i_wb_rst sampled high at an edge puts every output to 0 and the state to IDLE after that edge. This includes a reset mid-transfer; the pending ack is lost.
- **Write:** ack at T+1; throughput of one write per 2 cycles.
- **Read:**
  - o_reg_re in T+1.
  - i_reg_data sampled at the end of cycle T+1+RD_LAT.
  - ack in T+2+RD_LAT.
- **Error or discarded access:** response at T+1.
- **Back-to-back:** a new request is accepted no earlier than the cycle after RESP.

## Configuration
- **WB_ERR_EN defined:**
  - An invalid address gives o_wb_err = 1 in T+1, with o_wb_ack = 0.
  - o_wb_data is unchanged.
- **WB_ERR_EN undefined:**
  - o_wb_err is tied to 0.
  - An invalid address gives o_wb_ack = 1 in T+1.
  - A write is discarded.
  - A read loads o_wb_data = 0.

## Test plan
- **Write:** defaults, write adr 0x0004 with data 0xABCD, sel 2'b11 → T+1: o_reg_we = 1, o_reg_idx = 2, o_reg_data = 0xABCD, o_reg_sel = 2'b11, o_wb_ack = 1. T+2: ack = 0, we = 0.
- **Read with latency:** RD_LAT = 2, read adr 0x0006, i_reg_data = 0x1234 from T+3 → o_reg_re in T+1, o_reg_idx = 3, ack and o_wb_data = 0x1234 in T+4, ack low in T+5.
- **Invalid address:** adr 0x0003, then adr 0x0008 (NUM_REGS = 4), both reads.
  - With WB_ERR_EN: o_wb_err pulse at T+1, no reg strobe, o_wb_data unchanged.
  - Without WB_ERR_EN: ack at T+1 with o_wb_data = 0.
- **Base and stride:** BASE_ADR = 0x0100, STRIDE = 4, NUM_REGS = 8.
  - Write 0x010C → o_reg_idx = 3.
  - Write 0x010E → invalid.
  - Write 0x00FC → invalid.
- **Abort:** RD_LAT = 3, read started, cyc dropped in T+2 → no ack, IDLE by T+3, next write accepted normally.
- **Reset mid-transfer:** sync reset asserted in T+2 of an RD_LAT = 3 read → all outputs 0 after the edge, no ack; a following write completes at T'+1.
